// File: rtl/dc_mem_resp_if.sv
// Data-side SRAM-like bus between the DC memory responder (master) and the data bus arbiter (slave).
interface dc_mem_resp_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dc_mem_resp.sv
// DC-stage data memory responder: one outstanding bus access, result valid two cycles after accept on a zero-wait bus.
// Holds the pipe via stallreq while in flight; the result is held in DONE for as long as pipe_hold is high.
module dc_mem_resp #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              pipe_hold,
  output logic              stallreq,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  dc_mem_resp_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [TO_W-1:0] to_cnt;
  logic        capture;
  logic        timeout;
  logic        to_last;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  assign to_last = (to_cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: if (req_en) state_nx = ADDR;
      ADDR: begin
        if (bus.data_addr_ok && bus.data_data_ok) begin
          state_nx = DONE;
          capture  = 1'b1;
        end else if (bus.data_addr_ok) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (bus.data_data_ok) begin
          state_nx = DONE;
          capture  = 1'b1;
        end
      end
      DONE: if (!pipe_hold) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A completion landing on the last allowed cycle still wins over the timeout.
    if ((state == ADDR || state == DATA) && !capture && to_last) begin
      state_nx = DONE;
      timeout  = 1'b1;
    end
  end

  always_comb begin
    byte_sel = bus.data_rdata[7:0];
    case (lat_addr[1:0])
      2'd0: byte_sel = bus.data_rdata[7:0];
      2'd1: byte_sel = bus.data_rdata[15:8];
      2'd2: byte_sel = bus.data_rdata[23:16];
      default: byte_sel = bus.data_rdata[31:24];
    endcase
    half_sel = lat_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (lat_size)
      2'd0:    load_ext = {{24{~lat_uns & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{~lat_uns & half_sel[15]}}, half_sel};
      default: load_ext = bus.data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_size   <= 2'd0;
      lat_uns    <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      to_cnt     <= '0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_en) begin
        lat_we    <= req_we;
        lat_size  <= req_size;
        lat_uns   <= req_unsigned;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        to_cnt    <= '0;
      end else if (state == ADDR || state == DATA) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (capture) begin
        resp_rdata <= lat_we ? 32'd0 : load_ext;
        resp_err   <= 1'b0;
      end else if (timeout) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b1;
      end else if (state == DONE && !pipe_hold) begin
        resp_err <= 1'b0;
      end
    end
  end

  // Stall in the accept cycle itself so the DC stage freezes before the bus is even asked.
  assign stallreq   = (state == IDLE && req_en && rst) || state == ADDR || state == DATA;
  assign resp_valid = (state == DONE);

  assign bus.data_req   = (state == ADDR);
  assign bus.data_wr    = lat_we;
  assign bus.data_size  = lat_size;
  assign bus.data_addr  = lat_addr;
  assign bus.data_wdata = lat_wdata;

endmodule

// File: tb/tb_dc_mem_resp.sv
// Randomized bench for dc_mem_resp: per-transaction expectations come from the access rules, the bus follows a delay schedule.
module tb_dc_mem_resp;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_en = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        pipe_hold = 1'b0;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_chk = 0;
  int n_bad = 0;

  dc_mem_resp_if bus ();

  dc_mem_resp #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_en       (req_en),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .pipe_hold    (pipe_hold),
    .stallreq     (stallreq),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic we, input logic [1:0] sz, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    int off;
    off = int'(addr[1:0]);
    if (we) return 32'd0;
    if (sz == 2'd0) begin
      v = (rdata >> (8 * off)) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // da: ADDR cycle index (0 = first) where addr_ok comes; dd: further cycles until data_ok.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int da, input int dd, input int hold);
    int c, exp_stall, exp_req, exp_done_i, stall_n, req_n, done_n, done_i, i;
    bit to, fin;
    logic [31:0] exp_rd;
    c = da + dd;
    to = (c >= TO);
    exp_rd = to ? 32'd0 : ref_load(we, sz, uns, addr, rdata);
    exp_stall = 1 + (to ? TO : c + 1);
    exp_req = (da + 1 < TO) ? da + 1 : TO;
    exp_done_i = to ? TO : c + 1;
    stall_n = 0; req_n = 0; done_n = 0; done_i = -1; fin = 0;

    @(posedge clk); #1;
    req_en = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; pipe_hold = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(negedge clk);
    check_val("stall_accept", {31'd0, stallreq}, 32'd1);
    if (stallreq) stall_n++;

    i = 0;
    while (!fin && i < 300) begin
      @(posedge clk); #1;
      // Upstream is frozen, but scramble request fields to prove the responder latched them.
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_we    = 1'($urandom);
      req_size  = 2'($urandom);
      bus.data_addr_ok = (i == da);
      bus.data_data_ok = (i == c) || (i < da && $urandom_range(0, 3) == 0);
      bus.data_rdata   = (i == c) ? rdata : $urandom;
      pipe_hold = resp_valid ? (done_n < hold) : 1'($urandom);
      @(negedge clk);
      if (stallreq) stall_n++;
      if (bus.data_req) begin
        req_n++;
        check_val("bus_addr", bus.data_addr, addr);
        check_val("bus_wr", {31'd0, bus.data_wr}, {31'd0, we});
        check_val("bus_size", {30'd0, bus.data_size}, {30'd0, sz});
        check_val("bus_wdata", bus.data_wdata, wdata);
      end
      if (resp_valid) begin
        if (done_i < 0) done_i = i;
        done_n++;
        check_val("resp_rdata", resp_rdata, exp_rd);
        check_val("resp_err", {31'd0, resp_err}, {31'd0, to});
        check_val("stall_in_done", {31'd0, stallreq}, 32'd0);
        if (!pipe_hold) fin = 1;
      end
      i++;
    end
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    check_val("txn_finished", {31'd0, fin}, 32'd1);
    check_val("stall_cycles", stall_n, exp_stall);
    check_val("req_cycles", req_n, exp_req);
    check_val("done_index", done_i, exp_done_i);
    check_val("done_cycles", done_n, hold + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stall"}, {31'd0, stallreq}, 32'd0);
    check_val({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    check_val({tag, "_rdata"}, resp_rdata, 32'd0);
    check_val({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    check_val({tag, "_req"}, {31'd0, bus.data_req}, 32'd0);
    check_val({tag, "_wr"}, {31'd0, bus.data_wr}, 32'd0);
    check_val({tag, "_size"}, {30'd0, bus.data_size}, 32'd0);
    check_val({tag, "_addr"}, bus.data_addr, 32'd0);
    check_val({tag, "_wdata"}, bus.data_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_txn(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_txn(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'h0, 32'h80FF_0000, 1, 1, 0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'h0, 32'h80FF_0000, 0, 2, 0);
    run_txn(1'b1, 2'd0, 1'b0, 32'h2000_0001, 32'h5A5A_5A5A, 32'h1234_5678, 3, 2, 0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h3000_0002, 32'h0, 32'hC3A5_0F0F, 0, 1, 3);
    run_txn(1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'h0, 32'h1111_2222, 100, 0, 0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h4000_0008, 32'h0, 32'h3333_4444, 2, 3, 2);

    for (int k = 0; k < 60; k++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while waiting in DATA, then a stale data_ok arrives in IDLE.
    @(posedge clk); #1;
    req_en = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h5000_0010; pipe_hold = 1'b0;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    check_val("rst_pre_req", {31'd0, bus.data_req}, 32'd0);
    check_val("rst_pre_stall", {31'd0, stallreq}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    req_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'hFEED_F00D;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    check_all_zero("late_ok");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
